wbx_arbiter: RTL and testbench

Wishbone B4 pipelined multi-master arbiter placed in front of the single-master interconnect `wbx_1master`. It lets several masters share the one master port, for example the MCU plus a DMA or a debug bridge. Ownership is granted per bus cycle: it is taken when `CYC` rises and released when `CYC` falls and all acks are back. The arbiter tracks outstanding pipelined requests, throttles them, and drains stale acks before the bus is handed to another master.

---
 rtl/wbx_pkg.sv | 14 +
 rtl/wbx_arbiter_if.sv | 46 ++++
 rtl/wbx_arbiter_pick.sv | 30 +++
 rtl/wbx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wbx_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wbx_pkg.sv
// Shared types and bus widths for the wbx multi-master arbiter.
package wbx_pkg;

  localparam int WBX_ADR_W = 16;
  localparam int WBX_SEL_W = 4;
  localparam int WBX_DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } wbx_arb_state_t;

endpackage

// File: rtl/wbx_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the wbx_1master port.
// Handshake: stb is valid, !stall is ready; a request transfers on any cycle with
// cyc & stb & !stall, and exactly one ack returns later for each transferred request.
interface wbx_arbiter_if
  import wbx_pkg::*;
#(
  parameter int MASTER_NUM = 2
);

  logic [MASTER_NUM-1:0]           wbm_cyc_o;
  logic [MASTER_NUM-1:0]           wbm_stb_o;
  logic [MASTER_NUM-1:0]           wbm_we_o;
  logic [MASTER_NUM*WBX_ADR_W-1:0] wbm_adr_o;
  logic [MASTER_NUM*WBX_SEL_W-1:0] wbm_sel_o;
  logic [MASTER_NUM*WBX_DAT_W-1:0] wbm_dat_o;
  logic [WBX_DAT_W-1:0]            wbm_dat_i;
  logic [MASTER_NUM-1:0]           wbm_stall_i;
  logic [MASTER_NUM-1:0]           wbm_ack_i;

  logic                            wbs_cyc_i;
  logic                            wbs_stb_i;
  logic                            wbs_we_i;
  logic [WBX_ADR_W-1:0]            wbs_adr_i;
  logic [WBX_SEL_W-1:0]            wbs_sel_i;
  logic [WBX_DAT_W-1:0]            wbs_dat_i;
  logic [WBX_DAT_W-1:0]            wbs_dat_o;
  logic                            wbs_stall_o;
  logic                            wbs_ack_o;

  // Arbiter view: takes master requests and the downstream response.
  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    input  wbs_dat_o, wbs_stall_o, wbs_ack_o,
    output wbm_dat_i, wbm_stall_i, wbm_ack_i,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i
  );

  // Environment view: the masters plus the downstream wbx_1master port.
  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
    output wbs_dat_o, wbs_stall_o, wbs_ack_o,
    input  wbm_dat_i, wbm_stall_i, wbm_ack_i,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i
  );

endinterface

// File: rtl/wbx_arbiter_pick.sv
// Combinational picker: first requester found searching upward from start_i, wrapping.
module wbx_arbiter_pick #(
  parameter int MASTER_NUM = 2,
  parameter int PTR_W      = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req_i,
  input  logic [PTR_W-1:0]      start_i,
  output logic [MASTER_NUM-1:0] gnt_o
);

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      sum = {1'b0, start_i} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(MASTER_NUM)) sum = sum - (PTR_W+1)'(MASTER_NUM);
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbx_arbiter.sv
// Wishbone B4 pipelined multi-master arbiter in front of wbx_1master.
// Define WBX_ARBITER_ROUND_ROBIN_EN for round-robin picking; otherwise lowest index wins.
module wbx_arbiter
  import wbx_pkg::*;
#(
  parameter int MASTER_NUM    = 2,
  parameter int MAX_PENDING   = 4,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_ni,
  wbx_arbiter_if.slave                       bus,
  output logic [MASTER_NUM-1:0]              grant_o,
  output wbx_arb_state_t                     dbg_state_o,
  output logic [$clog2(MAX_PENDING+1)-1:0]   dbg_pending_o
);

  localparam int PTR_W = $clog2(MASTER_NUM);
  localparam int PCW   = $clog2(MAX_PENDING+1);
  localparam int TW    = $clog2(DRAIN_TIMEOUT+1);
  localparam logic [PCW-1:0] PEND_MAX = PCW'(MAX_PENDING);
  localparam logic [TW-1:0]  TMO_LAST = TW'(DRAIN_TIMEOUT-1);

  wbx_arb_state_t          state_q;
  logic [MASTER_NUM-1:0]   grant_q;
  logic [PCW-1:0]          pending_q, pending_nxt;
  logic [TW-1:0]           drain_cnt_q;
  logic [MASTER_NUM-1:0]   pick_gnt;
  logic [PTR_W-1:0]        pick_start;

  logic                    gnt_cyc, gnt_stb, gnt_we;
  logic [WBX_ADR_W-1:0]    gnt_adr;
  logic [WBX_SEL_W-1:0]    gnt_sel;
  logic [WBX_DAT_W-1:0]    gnt_dat;
  logic                    pend_full, stb_out, accept, ack_dec;
  logic [MASTER_NUM-1:0]   stall_vec, ack_vec;

`ifdef WBX_ARBITER_ROUND_ROBIN_EN
  logic [PTR_W-1:0]        rr_ptr_q, win_idx, rr_ptr_nxt;
  assign pick_start = rr_ptr_q;

  always_comb begin
    win_idx = '0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (pick_gnt[m]) win_idx = PTR_W'(m);
    end
    rr_ptr_nxt = (win_idx == PTR_W'(MASTER_NUM-1)) ? '0 : win_idx + 1'b1;
  end
`else
  assign pick_start = '0;
`endif

  wbx_arbiter_pick #(
    .MASTER_NUM (MASTER_NUM),
    .PTR_W      (PTR_W)
  ) u_pick (
    .req_i   (bus.wbm_cyc_o),
    .start_i (pick_start),
    .gnt_o   (pick_gnt)
  );

  // AND-OR mux on the registered grant: an empty grant yields all-zero downstream.
  always_comb begin
    gnt_cyc = 1'b0;
    gnt_stb = 1'b0;
    gnt_we  = 1'b0;
    gnt_adr = '0;
    gnt_sel = '0;
    gnt_dat = '0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (grant_q[m]) begin
        gnt_cyc = gnt_cyc | bus.wbm_cyc_o[m];
        gnt_stb = gnt_stb | bus.wbm_stb_o[m];
        gnt_we  = gnt_we  | bus.wbm_we_o[m];
        gnt_adr = gnt_adr | bus.wbm_adr_o[m*WBX_ADR_W +: WBX_ADR_W];
        gnt_sel = gnt_sel | bus.wbm_sel_o[m*WBX_SEL_W +: WBX_SEL_W];
        gnt_dat = gnt_dat | bus.wbm_dat_o[m*WBX_DAT_W +: WBX_DAT_W];
      end
    end
  end

  assign pend_full = (pending_q >= PEND_MAX);
  assign stb_out   = gnt_cyc & gnt_stb & ~pend_full;
  assign accept    = stb_out & ~bus.wbs_stall_o;
  assign ack_dec   = bus.wbs_ack_o & (pending_q != '0);

  always_comb begin
    pending_nxt = pending_q;
    case ({accept, ack_dec})
      2'b10:   pending_nxt = pending_q + 1'b1;
      2'b01:   pending_nxt = pending_q - 1'b1;
      default: pending_nxt = pending_q;
    endcase
  end

  always_comb begin
    stall_vec = '1;
    ack_vec   = '0;
    for (int m = 0; m < MASTER_NUM; m++) begin
      if (grant_q[m]) begin
        stall_vec[m] = bus.wbs_stall_o | pend_full;
        ack_vec[m]   = bus.wbs_ack_o;
      end
    end
  end

  assign bus.wbs_cyc_i   = gnt_cyc;
  assign bus.wbs_stb_i   = stb_out;
  assign bus.wbs_we_i    = gnt_we;
  assign bus.wbs_adr_i   = gnt_adr;
  assign bus.wbs_sel_i   = gnt_sel;
  assign bus.wbs_dat_i   = gnt_dat;
  assign bus.wbm_dat_i   = bus.wbs_dat_o;
  assign bus.wbm_stall_i = stall_vec;
  assign bus.wbm_ack_i   = ack_vec;

  assign grant_o       = grant_q;
  assign dbg_state_o   = state_q;
  assign dbg_pending_o = pending_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      pending_q   <= '0;
      drain_cnt_q <= '0;
`ifdef WBX_ARBITER_ROUND_ROBIN_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      pending_q <= pending_nxt;
      case (state_q)
        IDLE: begin
          if (|bus.wbm_cyc_o) begin
            grant_q <= pick_gnt;
            state_q <= OWNED;
`ifdef WBX_ARBITER_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_nxt;
`endif
          end
        end
        OWNED: begin
          if (!gnt_cyc) begin
            grant_q     <= '0;
            drain_cnt_q <= '0;
            // Requests still in flight make this an aborted cycle: their acks must be eaten.
            state_q     <= (pending_nxt == '0) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (pending_nxt == '0) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
          end else if (drain_cnt_q == TMO_LAST) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            drain_cnt_q <= '0;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbx_arbiter.sv
// Directed bench for wbx_arbiter (MASTER_NUM=2, MAX_PENDING=4, DRAIN_TIMEOUT=15).
module tb_wbx_arbiter;
  import wbx_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [1:0]     grant;
  wbx_arb_state_t dbg_state;
  logic [2:0]     dbg_pending;

  int tests_run = 0;
  int tests_failed = 0;

  wbx_arbiter_if #(.MASTER_NUM(2)) bus ();

  wbx_arbiter #(
    .MASTER_NUM    (2),
    .MAX_PENDING   (4),
    .DRAIN_TIMEOUT (15)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .bus           (bus),
    .grant_o       (grant),
    .dbg_state_o   (dbg_state),
    .dbg_pending_o (dbg_pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [15:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    bus.wbm_cyc_o[m]          = cyc;
    bus.wbm_stb_o[m]          = stb;
    bus.wbm_we_o[m]           = we;
    bus.wbm_adr_o[m*16 +: 16] = adr;
    bus.wbm_sel_o[m*4 +: 4]   = sel;
    bus.wbm_dat_o[m*32 +: 32] = dat;
  endtask

  task automatic slv(input logic stall, input logic ack, input logic [31:0] dat);
    bus.wbs_stall_o = stall;
    bus.wbs_ack_o   = ack;
    bus.wbs_dat_o   = dat;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_grant"}, 64'(grant), 64'(0));
    chk({pfx, "_cyc"},   64'(bus.wbs_cyc_i), 64'(0));
    chk({pfx, "_stb"},   64'(bus.wbs_stb_i), 64'(0));
    chk({pfx, "_we"},    64'(bus.wbs_we_i), 64'(0));
    chk({pfx, "_adr"},   64'(bus.wbs_adr_i), 64'(0));
    chk({pfx, "_sel"},   64'(bus.wbs_sel_i), 64'(0));
    chk({pfx, "_dat"},   64'(bus.wbs_dat_i), 64'(0));
    chk({pfx, "_stall"}, 64'(bus.wbm_stall_i), 64'(2'b11));
    chk({pfx, "_ack"},   64'(bus.wbm_ack_i), 64'(0));
    chk({pfx, "_state"}, 64'(dbg_state), 64'(IDLE));
    chk({pfx, "_pend"},  64'(dbg_pending), 64'(0));
  endtask

  logic [1:0]  exp_grant;
  logic [15:0] exp_adr;
  logic        exp_we;
  logic [3:0]  exp_sel;
  logic [31:0] exp_dat;
  int          acc_cnt;
  int          drain_cycles;

  initial begin
    drive_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    slv(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mid();
    chk_reset_outputs("init");

    // single master, three pipelined reads, slave acks two cycles after accept
    nxt(); drive_m(0, 1'b1, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    mid(); chk("sm_c0_stall", 64'(bus.wbm_stall_i), 64'(2'b11));
    chk("sm_c0_cyc", 64'(bus.wbs_cyc_i), 64'(0));
    nxt();
    mid(); chk("sm_c1_grant", 64'(grant), 64'(2'b01));
    chk("sm_c1_cyc", 64'(bus.wbs_cyc_i), 64'(1));
    chk("sm_c1_stb", 64'(bus.wbs_stb_i), 64'(1));
    chk("sm_c1_adr", 64'(bus.wbs_adr_i), 64'(16'h0010));
    chk("sm_c1_stall", 64'(bus.wbm_stall_i), 64'(2'b10));
    nxt(); drive_m(0, 1'b1, 1'b1, 1'b0, 16'h0014, 4'hF, 32'h0);
    mid(); chk("sm_c2_adr", 64'(bus.wbs_adr_i), 64'(16'h0014));
    nxt(); drive_m(0, 1'b1, 1'b1, 1'b0, 16'h0018, 4'hF, 32'h0); slv(1'b0, 1'b1, 32'hCAFE0001);
    mid(); chk("sm_c3_ack", 64'(bus.wbm_ack_i), 64'(2'b01));
    chk("sm_c3_rdat", 64'(bus.wbm_dat_i), 64'(32'hCAFE0001));
    chk("sm_c3_pend", 64'(dbg_pending), 64'(2));
    nxt(); drive_m(0, 1'b1, 1'b0, 1'b0, 16'h0018, 4'hF, 32'h0); slv(1'b0, 1'b1, 32'hCAFE0002);
    mid(); chk("sm_c4_ack", 64'(bus.wbm_ack_i), 64'(2'b01));
    chk("sm_c4_stb", 64'(bus.wbs_stb_i), 64'(0));
    chk("sm_c4_pend", 64'(dbg_pending), 64'(2));
    nxt(); slv(1'b0, 1'b1, 32'hCAFE0003);
    mid(); chk("sm_c5_ack", 64'(bus.wbm_ack_i), 64'(2'b01));
    chk("sm_c5_pend", 64'(dbg_pending), 64'(1));
    nxt(); slv(1'b0, 1'b0, 32'h0); drive_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    mid(); chk("sm_c6_pend", 64'(dbg_pending), 64'(0));
    chk("sm_c6_grant", 64'(grant), 64'(2'b01));
    chk("sm_c6_cyc", 64'(bus.wbs_cyc_i), 64'(0));
    nxt();
    mid(); chk("sm_c7_state", 64'(dbg_state), 64'(IDLE));
    chk("sm_c7_grant", 64'(grant), 64'(0));

    // stray ack with nothing pending: forwarded, counter stays at zero
    nxt(); drive_m(0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    nxt(); slv(1'b0, 1'b1, 32'h0);
    mid(); chk("uf_ack", 64'(bus.wbm_ack_i), 64'(2'b01));
    nxt(); slv(1'b0, 1'b0, 32'h0); drive_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    mid(); chk("uf_pend", 64'(dbg_pending), 64'(0));
    nxt();
    mid(); chk("uf_idle", 64'(dbg_state), 64'(IDLE));

    // contention: both request together, M0 releases and re-requests during the idle cycle
    nxt();
    drive_m(0, 1'b1, 1'b0, 1'b0, 16'h0100, 4'h3, 32'h11111111);
    drive_m(1, 1'b1, 1'b0, 1'b1, 16'h0200, 4'hC, 32'h22222222);
    mid(); chk("ct_c0_stall", 64'(bus.wbm_stall_i), 64'(2'b11));
    nxt();
    mid(); chk("ct_c1_grant", 64'(grant), 64'(2'b01));
    chk("ct_c1_adr", 64'(bus.wbs_adr_i), 64'(16'h0100));
    chk("ct_c1_stall", 64'(bus.wbm_stall_i), 64'(2'b10));
    nxt(); drive_m(0, 1'b0, 1'b0, 1'b0, 16'h0100, 4'h3, 32'h11111111);
    mid(); chk("ct_rel_cyc", 64'(bus.wbs_cyc_i), 64'(0));
    nxt(); drive_m(0, 1'b1, 1'b0, 1'b0, 16'h0100, 4'h3, 32'h11111111);
    mid(); chk("ct_gap_state", 64'(dbg_state), 64'(IDLE));
    chk("ct_gap_grant", 64'(grant), 64'(0));
    nxt();
`ifdef WBX_ARBITER_ROUND_ROBIN_EN
    exp_grant = 2'b10; exp_adr = 16'h0200; exp_we = 1'b1; exp_sel = 4'hC; exp_dat = 32'h22222222;
`else
    exp_grant = 2'b01; exp_adr = 16'h0100; exp_we = 1'b0; exp_sel = 4'h3; exp_dat = 32'h11111111;
`endif
    mid(); chk("ct_2nd_grant", 64'(grant), 64'(exp_grant));
    chk("ct_2nd_adr", 64'(bus.wbs_adr_i), 64'(exp_adr));
    chk("ct_2nd_we", 64'(bus.wbs_we_i), 64'(exp_we));
    chk("ct_2nd_sel", 64'(bus.wbs_sel_i), 64'(exp_sel));
    chk("ct_2nd_dat", 64'(bus.wbs_dat_i), 64'(exp_dat));
    nxt(); bus.wbm_stb_o = 2'b11; slv(1'b1, 1'b0, 32'h0);
    mid(); chk("ct_stl_stb", 64'(bus.wbs_stb_i), 64'(1));
    chk("ct_stl_stall", 64'(bus.wbm_stall_i), 64'(2'b11));
    nxt(); bus.wbm_stb_o = 2'b00; bus.wbm_cyc_o = 2'b00; slv(1'b0, 1'b0, 32'h0);
    nxt();
    mid(); chk("ct_end_state", 64'(dbg_state), 64'(IDLE));

    // throttle: slave never acks, exactly MAX_PENDING accepts
    nxt(); drive_m(0, 1'b1, 1'b1, 1'b0, 16'h0040, 4'hF, 32'h0);
    acc_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      nxt();
      mid();
      if (bus.wbs_stb_i && !bus.wbs_stall_o) acc_cnt++;
    end
    chk("th_accepts", 64'(acc_cnt), 64'(4));
    chk("th_stall", 64'(bus.wbm_stall_i), 64'(2'b11));
    chk("th_stb", 64'(bus.wbs_stb_i), 64'(0));
    chk("th_pend", 64'(dbg_pending), 64'(4));

    // reset with the bus owned and traffic still asserted
    nxt(); rst_n = 1'b0;
    #1;
    chk_reset_outputs("mrst");
    drive_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    nxt(); rst_n = 1'b1;

    // abort with two pending, acks arrive three cycles after the drop
    nxt(); drive_m(0, 1'b1, 1'b1, 1'b0, 16'h0080, 4'hF, 32'h0);
    nxt();
    nxt();
    nxt(); drive_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drive_m(1, 1'b1, 1'b0, 1'b0, 16'h0300, 4'hF, 32'h0);
    mid(); chk("ab_n_pend", 64'(dbg_pending), 64'(2));
    chk("ab_n_cyc", 64'(bus.wbs_cyc_i), 64'(0));
    nxt();
    mid(); chk("ab_state", 64'(dbg_state), 64'(DRAIN));
    chk("ab_grant", 64'(grant), 64'(0));
    chk("ab_stall", 64'(bus.wbm_stall_i), 64'(2'b11));
    nxt();
    nxt(); slv(1'b0, 1'b1, 32'h0);
    mid(); chk("ab_ack1_swallow", 64'(bus.wbm_ack_i), 64'(0));
    nxt();
    mid(); chk("ab_ack2_swallow", 64'(bus.wbm_ack_i), 64'(0));
    chk("ab_ack2_pend", 64'(dbg_pending), 64'(1));
    chk("ab_ack2_state", 64'(dbg_state), 64'(DRAIN));
    nxt(); slv(1'b0, 1'b0, 32'h0);
    mid(); chk("ab_idle", 64'(dbg_state), 64'(IDLE));
    chk("ab_idle_pend", 64'(dbg_pending), 64'(0));
    nxt();
    mid(); chk("ab_m1_grant", 64'(grant), 64'(2'b10));
    chk("ab_m1_adr", 64'(bus.wbs_adr_i), 64'(16'h0300));
    nxt(); drive_m(1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    nxt();

    // drain timeout: one pending, no ack ever
    nxt(); drive_m(0, 1'b1, 1'b1, 1'b0, 16'h00C0, 4'hF, 32'h0);
    nxt();
    nxt(); drive_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    mid(); chk("to_pend", 64'(dbg_pending), 64'(1));
    drain_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      mid();
      if (dbg_state == DRAIN) drain_cycles++;
    end
    chk("to_cycles", 64'(drain_cycles), 64'(15));
    chk("to_state", 64'(dbg_state), 64'(IDLE));
    chk("to_pend0", 64'(dbg_pending), 64'(0));

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
